regfile_write_ctrl: RTL and testbench

Write-port controller for the 8×8-bit register file. After reset, and again on request, it sweeps every register to 0x00, because the register file's own reset does not clear its contents. In normal operation it shares the register file's single write port between two requesters, A (ALU writeback) and B (load/immediate path), using valid/ready handshakes and round-robin arbitration. It drives the register file's `reg_write`, `write_addr` and `write_data` directly; read ports are not touched.

---
 rtl/regfile_ctrl_pkg.sv | 18 +
 rtl/regfile_write_ctrl_if.sv | 33 +++
 rtl/rr_arbiter2.sv | 40 ++++
 rtl/regfile_write_ctrl.sv | 123 ++++++++++++
 tb/tb_regfile_write_ctrl.sv | 173 +++++++++++++++++
 5 files changed

// File: rtl/regfile_ctrl_pkg.sv
// Shared types and defaults for the register-file write-port controller.
package regfile_ctrl_pkg;

  localparam int unsigned DefaultDataW   = 8;
  localparam int unsigned DefaultAddrW   = 3;
  localparam int unsigned DefaultNumRegs = 8;

  typedef enum logic {
    StClear = 1'b0,
    StRun   = 1'b1
  } state_e;

  typedef enum logic {
    GrantA = 1'b0,
    GrantB = 1'b1
  } grant_e;

endpackage

// File: rtl/regfile_write_ctrl_if.sv
// Requester handshakes plus the register-file write port driven by the controller.
interface regfile_write_ctrl_if #(
  parameter int unsigned DATA_W = 8,
  parameter int unsigned ADDR_W = 3
);

  logic              a_valid;
  logic [ADDR_W-1:0] a_addr;
  logic [DATA_W-1:0] a_data;
  logic              a_ready;

  logic              b_valid;
  logic [ADDR_W-1:0] b_addr;
  logic [DATA_W-1:0] b_data;
  logic              b_ready;

  logic              rf_reg_write;
  logic [ADDR_W-1:0] rf_write_addr;
  logic [DATA_W-1:0] rf_write_data;

  // Requester/environment side.
  modport master (
    output a_valid, a_addr, a_data, b_valid, b_addr, b_data,
    input  a_ready, b_ready, rf_reg_write, rf_write_addr, rf_write_data
  );

  // Controller side.
  modport slave (
    input  a_valid, a_addr, a_data, b_valid, b_addr, b_data,
    output a_ready, b_ready, rf_reg_write, rf_write_addr, rf_write_data
  );

endinterface

// File: rtl/rr_arbiter2.sv
// Two-input round-robin arbiter; last winner loses the next tie.
module rr_arbiter2
  import regfile_ctrl_pkg::*;
(
  input  logic clk_i,
  input  logic rst_ni,
  input  logic en_i,
  input  logic req_a_i,
  input  logic req_b_i,
  input  logic xfer_i,
  output logic gnt_a_o,
  output logic gnt_b_o
);

  grant_e last_q, last_d;

  // Combinational grant: a lone requester wins, a tie goes to whoever did not win last.
  always_comb begin
    gnt_a_o = en_i & req_a_i & (~req_b_i | (last_q == GrantB));
    gnt_b_o = en_i & req_b_i & (~req_a_i | (last_q == GrantA));
  end

  // Remember the winner only when a transfer actually happens.
  always_comb begin
    last_d = last_q;
    if (xfer_i) begin
      last_d = gnt_a_o ? GrantA : GrantB;
    end
  end

  // Last-grant register; B after reset so A wins the first tie.
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      last_q <= GrantB;
    end else begin
      last_q <= last_d;
    end
  end

endmodule

// File: rtl/regfile_write_ctrl.sv
// Register-file write-port controller: clear sweep after reset / on request,
// then round-robin sharing of the write port between requesters A and B.
module regfile_write_ctrl
  import regfile_ctrl_pkg::*;
#(
  parameter int unsigned DATA_W   = DefaultDataW,
  parameter int unsigned ADDR_W   = DefaultAddrW,
  parameter int unsigned NUM_REGS = DefaultNumRegs
) (
  input  logic                 clk_i,
  input  logic                 rst_ni,
  input  logic                 clear_req_i,
  output logic                 init_done_o,
  regfile_write_ctrl_if.slave  bus
);

  localparam logic [ADDR_W-1:0] LastAddr = ADDR_W'(NUM_REGS - 1);

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] cnt_q, cnt_d;
  logic              we_q, we_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] data_q, data_d;
  logic              arb_en, gnt_a, gnt_b, xfer;

  // Requesters are only served in RUN, never while a clear is requested or reset is held.
  assign arb_en = rst_ni & (state_q == StRun) & ~clear_req_i;
  assign xfer   = gnt_a | gnt_b;

  rr_arbiter2 u_arb (
    .clk_i   (clk_i),
    .rst_ni  (rst_ni),
    .en_i    (arb_en),
    .req_a_i (bus.a_valid),
    .req_b_i (bus.b_valid),
    .xfer_i  (xfer),
    .gnt_a_o (gnt_a),
    .gnt_b_o (gnt_b)
  );

  assign bus.a_ready = gnt_a;
  assign bus.b_ready = gnt_b;

  // State and sweep-counter register.
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state_q <= StClear;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Next-state: sweep through all registers, then run until a clear is requested.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      StClear: begin
        cnt_d = cnt_q + ADDR_W'(1);
        if (cnt_q == LastAddr) begin
          state_d = StRun;
          cnt_d   = '0;
        end
      end
      StRun: begin
        // The request edge itself writes addr 0, so the sweep resumes at 1.
        if (clear_req_i) begin
          state_d = StClear;
          cnt_d   = ADDR_W'(1);
        end
      end
      default: begin
        state_d = StClear;
        cnt_d   = '0;
      end
    endcase
  end

  // Output next-values: clear writes, accepted transfers, or idle with addr/data held.
  always_comb begin
    we_d   = 1'b0;
    addr_d = addr_q;
    data_d = data_q;
    if (state_q == StClear) begin
      we_d   = 1'b1;
      addr_d = cnt_q;
      data_d = '0;
    end else if (clear_req_i) begin
      we_d   = 1'b1;
      addr_d = '0;
      data_d = '0;
    end else if (gnt_a) begin
      we_d   = 1'b1;
      addr_d = bus.a_addr;
      data_d = bus.a_data;
    end else if (gnt_b) begin
      we_d   = 1'b1;
      addr_d = bus.b_addr;
      data_d = bus.b_data;
    end
  end

  // Registered write port.
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      we_q   <= 1'b0;
      addr_q <= '0;
      data_q <= '0;
    end else begin
      we_q   <= we_d;
      addr_q <= addr_d;
      data_q <= data_d;
    end
  end

  assign bus.rf_reg_write  = we_q;
  assign bus.rf_write_addr = addr_q;
  assign bus.rf_write_data = data_q;
  assign init_done_o       = (state_q == StRun);

endmodule

// File: tb/tb_regfile_write_ctrl.sv
// Directed and randomized bench for regfile_write_ctrl against a queue-based model.
module tb_regfile_write_ctrl;

  logic clk = 1'b0;
  logic rst_n;
  logic clr;
  logic init_done;

  regfile_write_ctrl_if #(.DATA_W(8), .ADDR_W(3)) bus ();

  regfile_write_ctrl dut (
    .clk_i       (clk),
    .rst_ni      (rst_n),
    .clear_req_i (clr),
    .init_done_o (init_done),
    .bus         (bus)
  );

  always #5 clk = ~clk;

  // Register file fed by the DUT's write port; contents are not reset.
  logic [7:0] rf [8] = '{default: 8'hEE};
  always @(posedge clk) begin
    if (bus.rf_reg_write === 1'b1) rf[bus.rf_write_addr] <= bus.rf_write_data;
  end

  int chk = 0;
  int fails = 0;

  // Model: pending clear-sweep addresses, last winner, expected write port and contents.
  int         clear_q[$];
  bit         m_last_b = 1'b1;
  bit         m_we = 1'b0;
  logic [2:0] m_addr = '0;
  logic [7:0] m_data = '0;
  logic [7:0] m_rf [8] = '{default: 8'hEE};

  // Requester state (held until accepted).
  bit         a_v, b_v;
  logic [2:0] a_a, b_a;
  logic [7:0] a_d, b_d;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    chk++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_rf();
    for (int i = 0; i < 8; i++) check("rf_contents", 32'(rf[i]), 32'(m_rf[i]));
  endtask

  // One clock: drive inputs, check readies mid-cycle, check registered outputs after the edge.
  task automatic step();
    bit ga, gb;
    bus.a_valid = a_v; bus.a_addr = a_a; bus.a_data = a_d;
    bus.b_valid = b_v; bus.b_addr = b_a; bus.b_data = b_d;
    ga = 1'b0;
    gb = 1'b0;
    if (rst_n && clear_q.size() == 0 && !clr) begin
      if (a_v && b_v) begin
        if (m_last_b) ga = 1'b1;
        else gb = 1'b1;
      end else if (a_v) ga = 1'b1;
      else if (b_v) gb = 1'b1;
    end
    @(negedge clk);
    check("a_ready", 32'(bus.a_ready), 32'(ga));
    check("b_ready", 32'(bus.b_ready), 32'(gb));
    @(posedge clk);
    #1;
    if (m_we) m_rf[m_addr] = m_data;
    if (!rst_n) begin
      clear_q = {};
      for (int i = 0; i < 8; i++) clear_q.push_back(i);
      m_last_b = 1'b1;
      m_we = 1'b0; m_addr = '0; m_data = '0;
    end else if (clear_q.size() != 0) begin
      m_we = 1'b1; m_addr = 3'(clear_q.pop_front()); m_data = '0;
    end else if (clr) begin
      m_we = 1'b1; m_addr = '0; m_data = '0;
      for (int i = 1; i < 8; i++) clear_q.push_back(i);
    end else if (ga || gb) begin
      m_we = 1'b1;
      m_addr = ga ? a_a : b_a;
      m_data = ga ? a_d : b_d;
      m_last_b = gb;
    end else begin
      m_we = 1'b0;
    end
    check("rf_reg_write", 32'(bus.rf_reg_write), 32'(m_we));
    check("rf_write_addr", 32'(bus.rf_write_addr), 32'(m_addr));
    check("rf_write_data", 32'(bus.rf_write_data), 32'(m_data));
    check("init_done", 32'(init_done), 32'(clear_q.size() == 0));
    if (ga) a_v = 1'b0;
    if (gb) b_v = 1'b0;
  endtask

  initial begin
    rst_n = 1'b0; clr = 1'b0;
    a_v = 1'b0; a_a = '0; a_d = '0;
    b_v = 1'b0; b_a = '0; b_d = '0;

    // Reset, then the 8-write sweep with idle requesters.
    step(); step();
    rst_n = 1'b1;
    repeat (8) step();
    step();
    check_rf();
    for (int i = 0; i < 8; i++) check("rf_cleared", 32'(rf[i]), 32'h0);

    // A alone.
    a_v = 1'b1; a_a = 3'd3; a_d = 8'hA5;
    step(); step();
    check("rf3_after_a", 32'(rf[3]), 32'hA5);

    // Both continuously valid: grants alternate.
    repeat (6) begin
      a_v = 1'b1; a_a = 3'd1; a_d = 8'h11;
      b_v = 1'b1; b_a = 3'd2; b_d = 8'h22;
      step();
    end
    a_v = 1'b0; b_v = 1'b0;
    step();
    check_rf();

    // Same address from reset-idle: A first, B's data is final.
    rst_n = 1'b0; step(); rst_n = 1'b1;
    repeat (8) step();
    a_v = 1'b1; a_a = 3'd5; a_d = 8'h55;
    b_v = 1'b1; b_a = 3'd5; b_d = 8'h66;
    step(); step(); step();
    check("rf5_collision", 32'(rf[5]), 32'h66);
    check_rf();

    // Clear request while B waits.
    b_v = 1'b1; b_a = 3'd6; b_d = 8'h3C;
    clr = 1'b1; step(); clr = 1'b0;
    repeat (9) step();
    check("rf6_after_clear", 32'(rf[6]), 32'h3C);
    check("rf5_cleared", 32'(rf[5]), 32'h0);
    check_rf();

    // Reset in the middle of a sweep restarts it from addr 0.
    clr = 1'b1; step(); clr = 1'b0;
    repeat (3) step();
    rst_n = 1'b0; step(); rst_n = 1'b1;
    repeat (9) step();
    check_rf();

    // Randomized traffic with occasional clears and resets.
    repeat (400) begin
      if (!a_v && $urandom_range(0, 2) == 0) begin
        a_v = 1'b1; a_a = 3'($urandom); a_d = 8'($urandom);
      end
      if (!b_v && $urandom_range(0, 2) == 0) begin
        b_v = 1'b1; b_a = 3'($urandom); b_d = 8'($urandom);
      end
      clr = ($urandom_range(0, 29) == 0);
      rst_n = ($urandom_range(0, 99) != 0);
      step();
    end
    rst_n = 1'b1; clr = 1'b0; a_v = 1'b0; b_v = 1'b0;
    repeat (10) step();
    check_rf();

    $display("TB_RESULT checks=%0d failures=%0d", chk, fails);
    $finish;
  end

endmodule
